spart_receive: RTL and testbench
================================

SPART_RECEIVE -- requirements
Module: spart_receive

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-003 SHALL have port Enable, input, 1 bit: one-clk-wide tick at 16x the baud rate; all bit timing counts Enable ticks only.
REQ-004 SHALL have port RxD, input, 1 bit: serial line; idle high, 1 start (0), 8 data LSB-first, 1 stop (1).
REQ-005 SHALL have port IOCS, input, 1 bit: chip select; 0 holds the block in its reset state.
REQ-006 SHALL have port IORW, input, 1 bit: 1 = bus read.
REQ-007 SHALL have port IOADDR, input, 2 bits: register select; 2'b00 = receive buffer.
REQ-008 SHALL have port Rx_Data, output, 8 bits: registered receive buffer; valid while RDA = 1.
REQ-009 SHALL have port RDA, output, 1 bit: receive data available.
REQ-010 SHALL have port FE, output, 1 bit: sticky framing error.
REQ-011 SHALL have port OVR, output, 1 bit: sticky overrun.

Function
REQ-012 SHALL implement states IDLE, START, DATA, STOP, BREAK; tick counter 4 bits, bit counter 3 bits, 8-bit shift register.
REQ-013 IDLE: on an Enable tick with rx = 0 SHALL go to START with tick counter = 0; otherwise stay.
REQ-014 START: on the 8th Enable tick (mid start bit) SHALL go to DATA if rx = 0, else return to IDLE (false start, no flags).
REQ-015 DATA: every 16th Enable tick SHALL shift rx into shift register MSB, shifting right; after the 8th bit SHALL go to STOP.
REQ-016 STOP: on the 16th Enable tick, rx = 1 SHALL load shift register into Rx_Data, set RDA, go to IDLE.
REQ-017 STOP: on the 16th Enable tick, rx = 0 SHALL set FE, leave Rx_Data and RDA unchanged, go to BREAK.
REQ-018 BREAK: SHALL return to IDLE only on an Enable tick with rx = 1.
REQ-019 Counters SHALL advance only on Enable ticks; no Enable means no state or counter change.
REQ-020 RDA SHALL be 1 in the clk cycle after the stop-bit sampling tick.
REQ-021 A read (IOCS = 1, IORW = 1, IOADDR = 2'b00) SHALL clear RDA, FE and OVR on the next clk edge.
REQ-022 Byte completion while RDA = 1 and no read in that cycle SHALL overwrite Rx_Data and set OVR.
REQ-023 Byte completion in the same cycle as a read SHALL load new data, keep RDA = 1, and leave OVR = 0.
REQ-024 Reads with IOADDR != 2'b00 or IORW = 0 SHALL not affect any state.

Reset
REQ-025 When rst = 0 or IOCS = 0, the next edge SHALL set state = IDLE, counters = 0, Rx_Data = 8'h00, RDA = 0, FE = 0, OVR = 0.
REQ-026 Reset mid-frame SHALL discard the partial byte; reception restarts at the next start bit seen after release.

Configuration
REQ-027 With macro SPART_RX_SYNC_EN defined, rx SHALL be RxD passed through a two-flop synchronizer, adding 2 clk of latency.
REQ-028 Without SPART_RX_SYNC_EN, rx SHALL be RxD used directly with no added flops; all other behaviour SHALL be identical.

Verification
REQ-029 Frame 8'hA5 at 16 ticks/bit -> RDA = 1 one clk after stop tick, Rx_Data = 8'hA5, FE = 0, OVR = 0.
REQ-030 RxD low for 4 ticks then high -> stays IDLE, RDA = 0, FE = 0; then frame 8'h3C -> Rx_Data = 8'h3C.
REQ-031 Frame 8'h55 with stop bit = 0, line held low 40 ticks, then high -> FE = 1, RDA = 0; next frame 8'h81 received correctly.
REQ-032 Frames 8'h11 then 8'h22, no read -> Rx_Data = 8'h22, RDA = 1, OVR = 1; read -> RDA = FE = OVR = 0.
REQ-033 Read asserted on the completion cycle of 8'h7E -> Rx_Data = 8'h7E, RDA = 1, OVR = 0.
REQ-034 rst = 0 for 1 clk during data bit 4 of a frame -> all outputs at reset values; next full frame 8'hF0 -> Rx_Data = 8'hF0.

Source files
------------

// File: rtl/spart_receive.sv
// SPART receiver: 16x-oversampled 8N1 deserializer with a one-byte receive buffer and RDA/FE/OVR flags.
// Latency: RDA rises one clk after the Enable tick that samples the middle of the stop bit (+2 clk with SPART_RX_SYNC_EN).
// Backpressure: none; a new byte always overwrites the buffer, and OVR records that an unread byte was lost.
//
// Ports:
//   clk, rst      - clock; synchronous active-low reset
//   Enable        - one-clk tick at 16x baud; all bit timing counts these ticks
//   RxD           - serial line (idle high, start 0, 8 data LSB first, stop 1)
//   IOCS, IORW    - chip select (0 holds the block in reset) and read strobe (1 = read)
//   IOADDR        - register select; 2'b00 is the receive buffer, whose read clears the flags
//   Rx_Data       - received byte, valid while RDA = 1
//   RDA, FE, OVR  - data available, sticky framing error, sticky overrun
// Build option: define SPART_RX_SYNC_EN to pass RxD through a two-flop synchronizer.

module spart_receive (
    input  logic       clk,
    input  logic       rst,
    input  logic       Enable,
    input  logic       RxD,
    input  logic       IOCS,
    input  logic       IORW,
    input  logic [1:0] IOADDR,
    output logic [7:0] Rx_Data,
    output logic       RDA,
    output logic       FE,
    output logic       OVR
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t     state;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       rx;
    logic       buf_read;

`ifdef SPART_RX_SYNC_EN
    logic sync_a;
    logic sync_b;

    // Synchronizer flops reset to the idle line level so release never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= RxD;
            sync_b <= sync_a;
        end
    end

    assign rx = sync_b;
`else
    assign rx = RxD;
`endif

    assign buf_read = IOCS && IORW && (IOADDR == 2'b00);

    always_ff @(posedge clk) begin
        if (!rst || !IOCS) begin
            state     <= IDLE;
            tick_cnt  <= 4'd0;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            Rx_Data   <= 8'h00;
            RDA       <= 1'b0;
            FE        <= 1'b0;
            OVR       <= 1'b0;
        end else begin
            // The read clear comes first so a byte completing in the same
            // cycle wins for RDA/FE while OVR stays cleared.
            if (buf_read) begin
                RDA <= 1'b0;
                FE  <= 1'b0;
                OVR <= 1'b0;
            end

            if (Enable) begin
                case (state)
                    IDLE: begin
                        if (!rx) begin
                            state    <= START;
                            tick_cnt <= 4'd0;
                        end
                    end

                    // Eight ticks after the falling edge we are mid start bit;
                    // a high line here is a glitch, not a frame.
                    START: begin
                        if (tick_cnt == 4'd7) begin
                            tick_cnt <= 4'd0;
                            bit_cnt  <= 3'd0;
                            state    <= rx ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end

                    DATA: begin
                        if (tick_cnt == 4'd15) begin
                            tick_cnt  <= 4'd0;
                            shift_reg <= {rx, shift_reg[7:1]};
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end

                    STOP: begin
                        if (tick_cnt == 4'd15) begin
                            tick_cnt <= 4'd0;
                            if (rx) begin
                                Rx_Data <= shift_reg;
                                RDA     <= 1'b1;
                                if (RDA && !buf_read) begin
                                    OVR <= 1'b1;
                                end
                                state <= IDLE;
                            end else begin
                                FE    <= 1'b1;
                                state <= BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end

                    // Wait out a held-low line so it is not mistaken for a new start bit.
                    BREAK: begin
                        if (rx) begin
                            state <= IDLE;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spart_receive.sv
// Testbench for spart_receive: directed frames plus random bytes and Enable spacing,
// checked against a byte-level model of the receive buffer and its flags.
module tb_spart_receive;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Enable = 1'b0;
    logic       RxD = 1'b1;
    logic       IOCS = 1'b1;
    logic       IORW = 1'b0;
    logic [1:0] IOADDR = 2'b00;
    logic [7:0] Rx_Data;
    logic       RDA;
    logic       FE;
    logic       OVR;

    int checks = 0;
    int failures = 0;

    // Reference model: the buffer contents and flags a bus master would expect.
    logic [7:0] m_data = 8'h00;
    logic       m_rda = 1'b0;
    logic       m_fe = 1'b0;
    logic       m_ovr = 1'b0;

    spart_receive dut (
        .clk(clk),
        .rst(rst),
        .Enable(Enable),
        .RxD(RxD),
        .IOCS(IOCS),
        .IORW(IORW),
        .IOADDR(IOADDR),
        .Rx_Data(Rx_Data),
        .RDA(RDA),
        .FE(FE),
        .OVR(OVR)
    );

    always #5 clk = ~clk;

    initial begin
        #20_000_000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"}, Rx_Data, m_data);
        chk({tag, ".rda"}, {7'd0, RDA}, {7'd0, m_rda});
        chk({tag, ".fe"}, {7'd0, FE}, {7'd0, m_fe});
        chk({tag, ".ovr"}, {7'd0, OVR}, {7'd0, m_ovr});
    endtask

    task automatic model_reset();
        m_data = 8'h00;
        m_rda  = 1'b0;
        m_fe   = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // One clk cycle: inputs driven on the falling edge, outputs settled 1 ns after the rising edge.
    task automatic cyc(input logic en, input logic rw, input logic [1:0] addr);
        @(negedge clk);
        Enable = en;
        IORW   = rw;
        IOADDR = addr;
        @(posedge clk);
        #1;
        Enable = 1'b0;
        IORW   = 1'b0;
        IOADDR = 2'b00;
    endtask

    // One Enable tick preceded by a random number of idle clocks.
    task automatic tick(input logic rd);
        int gap;
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 2'b00);
        cyc(1'b1, rd, 2'b00);
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) tick(1'b0);
    endtask

    task automatic do_read();
        cyc(1'b0, 1'b1, 2'b00);
        m_rda = 1'b0;
        m_fe  = 1'b0;
        m_ovr = 1'b0;
    endtask

    // Sends one frame, 16 ticks per bit. The receiver samples on the 9th tick of
    // each bit, so flags must be unchanged after 8 stop ticks and updated right
    // after the 9th. A frame with a low stop bit leaves the line low for the caller.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic rd, input string tag);
        logic old_rda;
        RxD = 1'b0;
        ticks(16);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            ticks(16);
        end
        RxD = stop;
        ticks(8);
        check_all({tag, ".pre"});
        tick(rd);
        old_rda = m_rda;
        if (rd) begin
            m_rda = 1'b0;
            m_fe  = 1'b0;
            m_ovr = 1'b0;
        end
        if (stop) begin
            if (old_rda && !rd) m_ovr = 1'b1;
            m_rda  = 1'b1;
            m_data = b;
        end else begin
            m_fe = 1'b1;
        end
        check_all({tag, ".stop"});
        if (stop) ticks(7);
    endtask

    initial begin
        // Reset
        repeat (3) cyc(1'b0, 1'b0, 2'b00);
        model_reset();
        check_all("reset");
        rst = 1'b1;
        ticks(20);
        check_all("idle");

        // Plain frame
        send_frame(8'hA5, 1'b1, 1'b0, "a5");
        do_read();
        check_all("a5_read");

        // False start: 4 low ticks only
        RxD = 1'b0;
        ticks(4);
        RxD = 1'b1;
        ticks(20);
        check_all("false_start");
        send_frame(8'h3C, 1'b1, 1'b0, "3c");
        do_read();

        // Framing error followed by a held-low line (40 ticks low in total)
        send_frame(8'h55, 1'b0, 1'b0, "55fe");
        ticks(31);
        check_all("break_low");
        RxD = 1'b1;
        ticks(20);
        check_all("break_high");
        send_frame(8'h81, 1'b1, 1'b0, "81");
        do_read();
        check_all("81_read");

        // Overrun
        send_frame(8'h11, 1'b1, 1'b0, "11");
        send_frame(8'h22, 1'b1, 1'b0, "22ovr");
        cyc(1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b1, 2'b01);
        cyc(1'b0, 1'b1, 2'b10);
        cyc(1'b0, 1'b1, 2'b11);
        check_all("not_a_read");
        do_read();
        check_all("ovr_read");

        // Read on the completion cycle with an unread byte pending
        send_frame(8'h11, 1'b1, 1'b0, "11b");
        send_frame(8'h7E, 1'b1, 1'b1, "7e_rd");

        // Reset pulse during data bit 4
        RxD = 1'b0;
        ticks(16);
        for (int i = 0; i < 4; i++) begin
            RxD = (i % 2 == 0) ? 1'b1 : 1'b0;
            ticks(16);
        end
        RxD = 1'b0;
        ticks(8);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_all("mid_reset");
        rst = 1'b1;
        RxD = 1'b1;
        ticks(20);
        send_frame(8'hF0, 1'b1, 1'b0, "f0");

        // Chip select low acts as reset
        @(negedge clk);
        IOCS = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_all("cs_low");
        IOCS = 1'b1;
        ticks(5);

        // Random bytes, reads and occasional framing errors
        for (int k = 0; k < 12; k++) begin
            logic [7:0] b;
            logic       good;
            b    = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            send_frame(b, good, ($urandom_range(0, 3) == 0), "rnd");
            if (!good) begin
                ticks(7);
                RxD = 1'b1;
                ticks(3);
            end
            if ($urandom_range(0, 1) == 1) do_read();
            ticks($urandom_range(0, 5));
            check_all("rnd_gap");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
